// File: rtl/uart_frame_demux.sv
// rtl/uart_frame_demux.sv - tagged-word demultiplexer with checksummed atomic frame commit
// Channel words fill shadow registers; a good commit copies every written channel to the outputs at once.
module uart_frame_demux #(
  parameter int DATA_W      = 16,
  parameter int TAG_W       = 4,
  parameter int NCH         = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic [NCH*(DATA_W-TAG_W)-1:0] ch_data,
  output logic [NCH-1:0]              dirty,
  output logic                        frame_valid,
  output logic                        chk_err,
  output logic                        tag_err,
  output logic                        link_lost
);

  localparam int PAY_W = DATA_W - TAG_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TAG_W-1:0] COMMIT = {TAG_W{1'b1}};
  localparam logic [TAG_W-1:0] NCH_T  = TAG_W'(NCH);
  localparam logic [CNT_W-1:0] T_CNT  = CNT_W'(TIMEOUT_CYC);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state;
  logic [PAY_W-1:0] shadow [NCH];
  logic [NCH-1:0]   wmask;
  logic [PAY_W-1:0] chk;
  logic [CNT_W-1:0] cnt;

  logic [TAG_W-1:0] tag;
  logic [PAY_W-1:0] pay;
  logic             is_ch, is_commit, chk_ok;
  logic [CNT_W-1:0] cnt_inc;

  assign tag       = in_data[DATA_W-1 -: TAG_W];
  assign pay       = in_data[PAY_W-1:0];
  assign is_ch     = (tag < NCH_T);
  assign is_commit = (tag == COMMIT);
  // An empty frame only commits with a zero checksum (keep-alive).
  assign chk_ok    = (state == IDLE) ? (pay == '0) : (pay == chk);
  assign cnt_inc   = (cnt == T_CNT) ? T_CNT : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wmask       <= '0;
      chk         <= '0;
      cnt         <= '0;
      ch_data     <= '0;
      dirty       <= '0;
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      tag_err     <= 1'b0;
      link_lost   <= 1'b0;
      for (int k = 0; k < NCH; k++) shadow[k] <= '0;
    end else begin
      frame_valid <= 1'b0;
      chk_err     <= 1'b0;
      tag_err     <= 1'b0;
      cnt         <= cnt_inc;
      if (cnt_inc == T_CNT) link_lost <= 1'b1;
      if (in_valid) begin
        if (is_ch) begin
          for (int k = 0; k < NCH; k++) begin
            if (tag == TAG_W'(k)) begin
              shadow[k] <= pay;
              wmask[k]  <= 1'b1;
            end
          end
          chk   <= chk ^ pay;
          state <= COLLECT;
        end else begin
          if (is_commit && chk_ok) begin
            for (int k = 0; k < NCH; k++) begin
              if (wmask[k]) ch_data[k*PAY_W +: PAY_W] <= shadow[k];
            end
            dirty       <= wmask;
            frame_valid <= 1'b1;
            cnt         <= '0;
            link_lost   <= 1'b0;
          end else if (is_commit) begin
            chk_err <= 1'b1;
          end else begin
            tag_err <= 1'b1;
          end
          wmask <= '0;
          chk   <= '0;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_demux.sv
// tb/tb_uart_frame_demux.sv - scoreboard bench for uart_frame_demux
// Stimulus pushes expected pulse responses; a negedge monitor pops and compares them.
module tb_uart_frame_demux;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int NCH    = 4;
  localparam int TMO    = 100;
  localparam int PAY_W  = DATA_W - TAG_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [DATA_W-1:0]      in_data = '0;
  logic                   in_valid = 1'b0;
  logic [NCH*PAY_W-1:0]   ch_data;
  logic [NCH-1:0]         dirty;
  logic                   frame_valid, chk_err, tag_err, link_lost;

  typedef struct {
    logic [2:0]           pulses;  // {frame_valid, chk_err, tag_err}
    logic [NCH*PAY_W-1:0] ch;
    logic [NCH-1:0]       dirty;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  uart_frame_demux #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NCH(NCH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .ch_data(ch_data), .dirty(dirty), .frame_valid(frame_valid),
    .chk_err(chk_err), .tag_err(tag_err), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [DATA_W-1:0] w);
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_resp(input logic [2:0] p, input logic [NCH*PAY_W-1:0] c, input logic [NCH-1:0] d);
    exp_t e;
    e.pulses = p; e.ch = c; e.dirty = d;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (frame_valid || chk_err || tag_err)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got fv/ce/te=%b ch=%h dirty=%b, expected none",
                 {frame_valid, chk_err, tag_err}, ch_data, dirty);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({frame_valid, chk_err, tag_err} !== e.pulses || ch_data !== e.ch || dirty !== e.dirty) begin
          n_err++;
          $display("FAIL response: got fv/ce/te=%b ch=%h dirty=%b, expected fv/ce/te=%b ch=%h dirty=%b",
                   {frame_valid, chk_err, tag_err}, ch_data, dirty, e.pulses, e.ch, e.dirty);
        end
      end
    end
  end

  localparam logic [2:0] FV = 3'b100, CE = 3'b010, TE = 3'b001;

  logic [NCH*PAY_W-1:0] ch_a, ch_b;

  initial begin
    ch_a = {12'h000, 12'h000, 12'h456, 12'h123};
    ch_b = {12'h333, 12'h000, 12'h456, 12'h222};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs", 64'({ch_data, dirty, frame_valid, chk_err, tag_err, link_lost}), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_no_pulse", 64'({frame_valid, chk_err, tag_err, link_lost}), 64'd0);
    end
    @(posedge clk); #1;

    // good frame
    send(16'h0123); send(16'h1456);
    expect_resp(FV, ch_a, 4'b0011); send(16'hF575);

    // bad checksum, then empty commit
    send(16'h0ABC);
    expect_resp(CE, ch_a, 4'b0011); send(16'hF000);
    expect_resp(FV, ch_a, 4'b0000); send(16'hF000);

    // illegal tag aborts the frame
    send(16'h2111);
    expect_resp(TE, ch_a, 4'b0000); send(16'h5999);
    expect_resp(CE, ch_a, 4'b0000); send(16'hF111);

    // watchdog
    expect_resp(FV, ch_a, 4'b0000); send(16'hF000);
    repeat (TMO - 1) @(posedge clk);
    #1 check("link_lost_before", 64'(link_lost), 64'd0);
    @(posedge clk); #1 check("link_lost_at_T", 64'(link_lost), 64'd1);
    repeat (5) @(posedge clk);
    #1 check("link_lost_sticky", 64'(link_lost), 64'd1);
    expect_resp(FV, ch_a, 4'b0000); send(16'hF000);
    check("link_lost_cleared", 64'(link_lost), 64'd0);

    // repeated channel, last value wins, checksum folds all writes
    send(16'h0111); send(16'h0222); send(16'h3333);
    expect_resp(FV, ch_b, 4'b1001); send(16'hF000);

    // reset mid-frame
    send(16'h3777);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midreset_outputs", 64'({ch_data, dirty, link_lost}), 64'd0);
    expect_resp(CE, '0, 4'b0000); send(16'hF777);

    repeat (4) @(posedge clk);
    #1 check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("ch3_after_reset", 64'(ch_data[3*PAY_W +: PAY_W]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
